// File: rtl/conv_host_pkg.sv
// Shared types and helpers for the convolution host buffer: FSM state encoding
// and the drain-length calculation.
package conv_host_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Full convolution output length n_y + size_h - 1, wrapped to the Z address width.
  function automatic int unsigned nz_count(input int unsigned n_y,
                                           input int unsigned size_h,
                                           input int unsigned width);
    return (n_y + size_h - 32'd1) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/conv_host_buffer_if.sv
// Y input stream and Z output stream between the bus/DMA front end (master)
// and the host buffer (slave).
interface conv_host_buffer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_WIDTH_OUT = 16
);

  logic                      y_valid_i;
  logic                      y_ready_o;
  logic [DATA_WIDTH-1:0]     y_data_i;
  logic                      y_last_i;
  logic                      z_valid_o;
  logic                      z_ready_i;
  logic [DATA_WIDTH_OUT-1:0] z_data_o;
  logic                      z_last_o;

  modport master (
    output y_valid_i, y_data_i, y_last_i, z_ready_i,
    input  y_ready_o, z_valid_o, z_data_o, z_last_o
  );

  modport slave (
    input  y_valid_i, y_data_i, y_last_i, z_ready_i,
    output y_ready_o, z_valid_o, z_data_o, z_last_o
  );

endinterface

// File: rtl/conv_buf_ram.sv
// Register-array buffer with one synchronous write port and one asynchronous
// read port; contents are never cleared.
module conv_buf_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_host_buffer.sv
// Host-side responder for one convolution engine: buffers the Y vector, starts
// the engine, serves its Y reads, captures its Z writes and streams Z back out.
module conv_host_buffer
  import conv_host_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_WIDTH_OUT    = 16,
  parameter int ADDRESS_WIDTH     = 5,
  parameter int ADDRESS_WIDTH_OUT = 6,
  parameter int SIZE_H            = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  conv_host_buffer_if.slave            host,
  output logic                         conv_start_o,
  output logic [ADDRESS_WIDTH-1:0]     conv_size_y_o,
  input  logic [ADDRESS_WIDTH-1:0]     conv_y_addr_i,
  output logic [DATA_WIDTH-1:0]        conv_data_y_o,
  input  logic [ADDRESS_WIDTH_OUT-1:0] conv_z_addr_i,
  input  logic [DATA_WIDTH_OUT-1:0]    conv_data_z_i,
  input  logic                         conv_write_i,
  input  logic                         conv_done_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam logic [ADDRESS_WIDTH-1:0] Y_MAX_COUNT = '1;

  state_t                       state;
  logic [ADDRESS_WIDTH-1:0]     n_y;
  logic [ADDRESS_WIDTH-1:0]     n_y_inc;
  logic [ADDRESS_WIDTH_OUT-1:0] p;
  logic [ADDRESS_WIDTH_OUT-1:0] p_inc;
  logic [ADDRESS_WIDTH_OUT-1:0] n_z;
  logic [ADDRESS_WIDTH_OUT-1:0] n_z_m1;
  logic [ADDRESS_WIDTH_OUT-1:0] n_z_calc;
  logic                         y_accept;
  logic                         y_final;
  logic                         z_accept;
  logic                         z_we;

  assign y_accept = host.y_ready_o & host.y_valid_i;
  assign z_accept = host.z_valid_o & host.z_ready_i;
  assign z_we     = (state == RUN) & conv_write_i;
  assign n_y_inc  = n_y + 1'b1;
  assign p_inc    = p + 1'b1;
  assign n_z_m1   = n_z - 1'b1;
  assign y_final  = host.y_last_i | (n_y_inc == Y_MAX_COUNT);
  assign n_z_calc = ADDRESS_WIDTH_OUT'(nz_count(32'(n_y), SIZE_H, ADDRESS_WIDTH_OUT));

  conv_buf_ram #(.WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDRESS_WIDTH)) u_y_ram (
    .clk   (clk),
    .we    (y_accept),
    .waddr (n_y),
    .wdata (host.y_data_i),
    .raddr (conv_y_addr_i),
    .rdata (conv_data_y_o)
  );

  conv_buf_ram #(.WIDTH(DATA_WIDTH_OUT), .ADDR_WIDTH(ADDRESS_WIDTH_OUT)) u_z_ram (
    .clk   (clk),
    .we    (z_we),
    .waddr (conv_z_addr_i),
    .wdata (conv_data_z_i),
    .raddr (p),
    .rdata (host.z_data_o)
  );

  // z_last_o is precomputed one beat ahead so the final handshake is just z_accept & z_last_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      n_y            <= '0;
      p              <= '0;
      n_z            <= '0;
      conv_size_y_o  <= '0;
      conv_start_o   <= 1'b0;
      host.y_ready_o <= 1'b1;
      host.z_valid_o <= 1'b0;
      host.z_last_o  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      conv_start_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        LOAD: begin
          if (y_accept) begin
            n_y <= n_y_inc;
            if (y_final) begin
              state          <= START;
              conv_start_o   <= 1'b1;
              conv_size_y_o  <= n_y_inc;
              host.y_ready_o <= 1'b0;
              busy_o         <= 1'b1;
            end
          end
        end
        START: state <= RUN;
        RUN: begin
          if (conv_done_i) begin
            state          <= DRAIN;
            n_z            <= n_z_calc;
            p              <= '0;
            host.z_valid_o <= 1'b1;
            host.z_last_o  <= (n_z_calc == ADDRESS_WIDTH_OUT'(1));
          end
        end
        DRAIN: begin
          if (z_accept) begin
            if (host.z_last_o) begin
              state          <= LOAD;
              n_y            <= '0;
              p              <= '0;
              host.z_valid_o <= 1'b0;
              host.z_last_o  <= 1'b0;
              host.y_ready_o <= 1'b1;
              busy_o         <= 1'b0;
              done_o         <= 1'b1;
            end else begin
              p             <= p_inc;
              host.z_last_o <= (p_inc == n_z_m1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_host_buffer.sv
// Directed bench for conv_host_buffer: instance A uses SIZE_H=4 for the short
// vectors, instance B uses SIZE_H=31 for the full-length load and drain.
module tb_conv_host_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_host_buffer_if #(.DATA_WIDTH(8), .DATA_WIDTH_OUT(16)) hif_a ();
  conv_host_buffer_if #(.DATA_WIDTH(8), .DATA_WIDTH_OUT(16)) hif_b ();

  logic        start_a, start_b, write_a, write_b, done_in_a, done_in_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [4:0]  size_a, size_b, y_addr_a, y_addr_b;
  logic [7:0]  data_y_a, data_y_b;
  logic [5:0]  z_addr_a, z_addr_b;
  logic [15:0] data_z_a, data_z_b;

  conv_host_buffer #(.SIZE_H(4)) dut_a (
    .clk(clk), .rst(rst), .host(hif_a),
    .conv_start_o(start_a), .conv_size_y_o(size_a),
    .conv_y_addr_i(y_addr_a), .conv_data_y_o(data_y_a),
    .conv_z_addr_i(z_addr_a), .conv_data_z_i(data_z_a),
    .conv_write_i(write_a), .conv_done_i(done_in_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  conv_host_buffer #(.SIZE_H(31)) dut_b (
    .clk(clk), .rst(rst), .host(hif_b),
    .conv_start_o(start_b), .conv_size_y_o(size_b),
    .conv_y_addr_i(y_addr_b), .conv_data_y_o(data_y_b),
    .conv_z_addr_i(z_addr_b), .conv_data_z_i(data_z_b),
    .conv_write_i(write_b), .conv_done_i(done_in_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  int checks = 0;
  int errors = 0;
  int expz [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Y beat on instance A, held for exactly one clock edge.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    hif_a.y_valid_i = 1'b1;
    hif_a.y_data_i  = d;
    hif_a.y_last_i  = last;
    tick();
    hif_a.y_valid_i = 1'b0;
    hif_a.y_last_i  = 1'b0;
  endtask

  task automatic engineWriteA(input int addr, input int data, input logic done);
    write_a   = 1'b1;
    z_addr_a  = 6'(addr);
    data_z_a  = 16'(data);
    done_in_a = done;
    tick();
    write_a   = 1'b0;
    done_in_a = 1'b0;
  endtask

  // Drain n beats from A against expz; stall inserts two idle cycles after the first beat.
  task automatic drainA(input int n, input bit stall);
    int p = 0;
    int c = 0;
    bit rdy;
    while (p < n && c < 256) begin
      rdy = !(stall && (c == 1 || c == 2));
      hif_a.z_ready_i = rdy;
      checkOutput("drain_valid", 32'(hif_a.z_valid_o), 1);
      checkOutput("drain_data", 32'(hif_a.z_data_o), expz[p]);
      checkOutput("drain_last", 32'(hif_a.z_last_o), (p == n - 1) ? 1 : 0);
      tick();
      if (rdy) p++;
      c++;
    end
    hif_a.z_ready_i = 1'b1;
    checkOutput("done_pulse", 32'(done_a), 1);
    checkOutput("ready_after_drain", 32'(hif_a.y_ready_o), 1);
    checkOutput("valid_after_drain", 32'(hif_a.z_valid_o), 0);
    checkOutput("busy_after_drain", 32'(busy_a), 0);
    tick();
    checkOutput("done_clear", 32'(done_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    hif_a.y_valid_i = 1'b0; hif_a.y_data_i = '0; hif_a.y_last_i = 1'b0; hif_a.z_ready_i = 1'b1;
    hif_b.y_valid_i = 1'b0; hif_b.y_data_i = '0; hif_b.y_last_i = 1'b0; hif_b.z_ready_i = 1'b1;
    write_a = 1'b0; done_in_a = 1'b0; y_addr_a = '0; z_addr_a = '0; data_z_a = '0;
    write_b = 1'b0; done_in_b = 1'b0; y_addr_b = '0; z_addr_b = '0; data_z_b = '0;
    tick();
    tick();
    checkOutput("rst_y_ready", 32'(hif_a.y_ready_o), 1);
    checkOutput("rst_z_valid", 32'(hif_a.z_valid_o), 0);
    checkOutput("rst_z_last", 32'(hif_a.z_last_o), 0);
    checkOutput("rst_start", 32'(start_a), 0);
    checkOutput("rst_size", 32'(size_a), 0);
    checkOutput("rst_busy", 32'(busy_a), 0);
    checkOutput("rst_done", 32'(done_a), 0);
    checkOutput("rst_b_valid", 32'(hif_b.z_valid_o), 0);
    rst = 1'b0;

    // Short vector, engine reads, Z writes with a write in the done cycle.
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd2, 1'b0);
    applyStimulus(8'd3, 1'b1);
    checkOutput("t1_start", 32'(start_a), 1);
    checkOutput("t1_size", 32'(size_a), 3);
    checkOutput("t1_y_ready_low", 32'(hif_a.y_ready_o), 0);
    checkOutput("t1_busy", 32'(busy_a), 1);
    for (int i = 0; i < 3; i++) begin
      y_addr_a = 5'(i);
      #1;
      checkOutput("t1_y_read", 32'(data_y_a), i + 1);
    end
    tick();
    checkOutput("t1_start_pulse_end", 32'(start_a), 0);
    checkOutput("t1_run_no_valid", 32'(hif_a.z_valid_o), 0);
    for (int i = 0; i < 5; i++) engineWriteA(i, 10 + i, 1'b0);
    engineWriteA(5, 15, 1'b1);
    for (int i = 0; i < 6; i++) expz[i] = 10 + i;
    drainA(6, 1'b0);

    // Engine strobes in LOAD are ignored; double write in RUN keeps the later value.
    engineWriteA(1, 16'h0077, 1'b1);
    checkOutput("t2_load_y_ready", 32'(hif_a.y_ready_o), 1);
    checkOutput("t2_load_busy", 32'(busy_a), 0);
    checkOutput("t2_load_z_valid", 32'(hif_a.z_valid_o), 0);
    applyStimulus(8'd4, 1'b0);
    applyStimulus(8'd5, 1'b1);
    checkOutput("t2_size", 32'(size_a), 2);
    tick();
    engineWriteA(2, 5, 1'b0);
    engineWriteA(2, 9, 1'b0);
    done_in_a = 1'b1;
    tick();
    done_in_a = 1'b0;
    expz[0] = 10; expz[1] = 11; expz[2] = 9; expz[3] = 13; expz[4] = 14;
    drainA(5, 1'b1);

    // Reset while the engine is running.
    applyStimulus(8'd7, 1'b0);
    applyStimulus(8'd8, 1'b1);
    tick();
    checkOutput("t3_run_busy", 32'(busy_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t3_rst_run_ready", 32'(hif_a.y_ready_o), 1);
    checkOutput("t3_rst_run_valid", 32'(hif_a.z_valid_o), 0);
    checkOutput("t3_rst_run_size", 32'(size_a), 0);
    checkOutput("t3_rst_run_busy", 32'(busy_a), 0);

    // Reset in the middle of a drain.
    applyStimulus(8'd6, 1'b0);
    applyStimulus(8'd7, 1'b1);
    tick();
    done_in_a = 1'b1;
    tick();
    done_in_a = 1'b0;
    checkOutput("t3_drain_valid", 32'(hif_a.z_valid_o), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t3_rst_drain_ready", 32'(hif_a.y_ready_o), 1);
    checkOutput("t3_rst_drain_valid", 32'(hif_a.z_valid_o), 0);
    checkOutput("t3_rst_drain_last", 32'(hif_a.z_last_o), 0);
    checkOutput("t3_rst_drain_size", 32'(size_a), 0);
    checkOutput("t3_rst_drain_done", 32'(done_a), 0);

    // Fresh two-sample run after reset.
    applyStimulus(8'd20, 1'b0);
    applyStimulus(8'd21, 1'b1);
    checkOutput("t4_size", 32'(size_a), 2);
    checkOutput("t4_start", 32'(start_a), 1);
    y_addr_a = 5'd0;
    #1;
    checkOutput("t4_y0", 32'(data_y_a), 20);
    y_addr_a = 5'd1;
    #1;
    checkOutput("t4_y1", 32'(data_y_a), 21);
    tick();
    for (int i = 0; i < 5; i++) engineWriteA(i, 100 + i, 1'b0);
    done_in_a = 1'b1;
    tick();
    done_in_a = 1'b0;
    for (int i = 0; i < 5; i++) expz[i] = 100 + i;
    drainA(5, 1'b0);

    // Instance B: 31 beats with no last flag, then a 61-beat drain.
    for (int i = 0; i < 31; i++) begin
      if (i == 30) checkOutput("b_ready_before_31st", 32'(hif_b.y_ready_o), 1);
      hif_b.y_valid_i = 1'b1;
      hif_b.y_data_i  = 8'(i + 1);
      hif_b.y_last_i  = 1'b0;
      tick();
    end
    hif_b.y_valid_i = 1'b0;
    checkOutput("b_ready_low", 32'(hif_b.y_ready_o), 0);
    checkOutput("b_size", 32'(size_b), 31);
    checkOutput("b_start", 32'(start_b), 1);
    checkOutput("b_busy", 32'(busy_b), 1);
    y_addr_b = 5'd30;
    #1;
    checkOutput("b_y30", 32'(data_y_b), 31);
    tick();
    for (int i = 0; i < 61; i++) begin
      write_b  = 1'b1;
      z_addr_b = 6'(i);
      data_z_b = 16'(3 * i + 1);
      tick();
    end
    write_b   = 1'b0;
    done_in_b = 1'b1;
    tick();
    done_in_b = 1'b0;
    for (int k = 0; k < 61; k++) begin
      checkOutput("b_drain_valid", 32'(hif_b.z_valid_o), 1);
      checkOutput("b_drain_data", 32'(hif_b.z_data_o), 3 * k + 1);
      checkOutput("b_drain_last", 32'(hif_b.z_last_o), (k == 60) ? 1 : 0);
      tick();
    end
    checkOutput("b_done", 32'(done_b), 1);
    checkOutput("b_ready_after", 32'(hif_b.y_ready_o), 1);
    checkOutput("b_valid_after", 32'(hif_b.z_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_host_buffer.md
# conv_host_buffer

Host-side companion of the convolution engine: the memory responder on the engine's Y-read and Z-write ports. Accepts a Y vector over a valid/ready stream into a local Y buffer, starts the engine with the captured length, serves its Y reads, and captures its Z writes into a local Z buffer. On engine completion it streams the Z vector out over a valid/ready stream. It sits between the system bus/DMA front end and one convolution engine instance.

## Interface
- DATA_WIDTH, 8, Y sample width
- DATA_WIDTH_OUT, 16, Z sample width
- ADDRESS_WIDTH, 5, Y address width; Y buffer depth 2^ADDRESS_WIDTH
- ADDRESS_WIDTH_OUT, 6, Z address width; Z buffer depth 2^ADDRESS_WIDTH_OUT
- SIZE_H, 31, length of the engine's H vector; must be ≤ 2^ADDRESS_WIDTH−1 and match the engine
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- y_valid_i / y_ready_o  in/out  1  Y input handshake
- y_data_i  in  DATA_WIDTH  Y sample
- y_last_i  in  1  final Y sample of the vector
- z_valid_o / z_ready_i  out/in  1  Z output handshake
- z_data_o  out  DATA_WIDTH_OUT  Z sample
- z_last_o  out  1  final Z sample
- conv_start_o  out  1  one-cycle start pulse to the engine
- conv_size_y_o  out  ADDRESS_WIDTH  captured Y length
- conv_y_addr_i  in  ADDRESS_WIDTH  engine Y read address
- conv_data_y_o  out  DATA_WIDTH  Y buffer word at conv_y_addr_i (combinational read)
- conv_z_addr_i  in  ADDRESS_WIDTH_OUT  engine Z write address
- conv_data_z_i  in  DATA_WIDTH_OUT  engine Z write data
- conv_write_i  in  1  engine Z write strobe
- conv_done_i  in  1  engine completion pulse
- busy_o  out  1  high whenever state ≠ LOAD
- done_o  out  1  one-cycle pulse after the last Z beat

## Operation
- States: LOAD → START → RUN → DRAIN → LOAD.
- LOAD: y_ready_o=1. Each accepted beat writes Y[n_y] and increments n_y. A beat is final when y_last_i=1 or n_y reaches 2^ADDRESS_WIDTH−1 (31). The final beat moves the FSM to START. y_ready_o=0 in all other states.
- START: conv_start_o=1 for exactly this cycle. conv_size_y_o=n_y, held stable until the next LOAD completes. Go to RUN.
- RUN: conv_write_i=1 writes conv_data_z_i to Z[conv_z_addr_i]. Repeated writes to one address are allowed; last write wins. conv_done_i → DRAIN. conv_write_i and conv_done_i are ignored outside RUN.
- DRAIN: n_z = n_y + SIZE_H − 1, computed at ADDRESS_WIDTH_OUT width with operands zero-extended (max 61, no overflow). Read pointer p starts at 0. z_valid_o=1, z_data_o=Z[p], z_last_o=(p==n_z−1). On a handshake p increments. The last handshake → LOAD, n_y cleared, done_o pulsed.
- A z_ready_i deassertion stalls DRAIN indefinitely; z_data_o and z_last_o hold.
- Y and Z buffers are not cleared by reset or between runs.
- Reset in any state: next state LOAD, counters zero, conv_size_y_o=0. Any in-flight engine run is abandoned; the engine must be reset together with this block.

## Timing
- Reset values: y_ready_o=1 (in LOAD after reset), z_valid_o=0, z_last_o=0, z_data_o=Z[0] (undefined content), conv_start_o=0, conv_size_y_o=0, busy_o=0, done_o=0.
- Final Y beat accepted at cycle t: conv_start_o=1 at t+1, RUN at t+2, busy_o=1 from t+1.
- conv_done_i at cycle d (in RUN): z_valid_o=1 at d+1. A Z write in cycle d is stored and visible to DRAIN.
- Last Z handshake at cycle e: done_o=1 and y_ready_o=1 at e+1. Throughput is one Z beat per cycle with z_ready_i held high.
- conv_data_y_o follows conv_y_addr_i in the same cycle.

## Structure
- Package conv_host_pkg: state enum typedef (LOAD, START, RUN, DRAIN) and n_z width constant helper.
- One sub-module, conv_buf_ram: parameterised single-write, async-read register array. Instantiated twice: Y (DATA_WIDTH × 2^ADDRESS_WIDTH) and Z (DATA_WIDTH_OUT × 2^ADDRESS_WIDTH_OUT).
- The FSM and counters live in conv_host_buffer.

## Test plan
- Load Y=[1,2,3] with last on 3, SIZE_H=4 → conv_start_o one pulse, conv_size_y_o=3; engine-model reads return 1,2,3 at addresses 0,1,2.
- Engine model writes Z[i]=10+i, i=0..5, then conv_done_i → exactly 6 beats 10..15, z_last_o only on 15, done_o one cycle later.
- 31 beats without y_last_i → load ends at the 31st beat, y_ready_o=0 next cycle, conv_size_y_o=31, n_z=61 beats drained.
- z_ready_i toggled 1,0,0,1 during DRAIN → z_data_o held during stalls, no beat lost or duplicated.
- conv_write_i/conv_done_i during LOAD → no Z change, state unchanged; double write to Z[2] (5 then 9) in RUN → drains 9.
- rst asserted mid-RUN and mid-DRAIN → next cycle LOAD, y_ready_o=1, z_valid_o=0, conv_size_y_o=0; a fresh 2-sample vector then runs correctly.
